// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA sequencer. A CPU write to DMA_REG_ADDR latches a
// source page. The block then stalls the CPU and copies 256 bytes from
// {page,00}..{page,FF} into PPU OAM, starting at the current OAMADDR.
//
// Ports:
//   clk, reset    system clock; synchronous active-high reset
//   cpu_ce        CPU-cycle strobe; all state advances only when it is high
//   cpu_addr      CPU bus address (trigger decode only)
//   cpu_WE        CPU bus write enable (trigger decode only)
//   cpu_data_in   CPU write data; source page on trigger
//   oam_base      live PPU OAMADDR; destination of byte 0
//   wram_data     WRAM read data for dma_addr
//   cpu_stall     CPU hold request (busy)
//   oam_dma       busy flag for the WRAM mapper; same as cpu_stall
//   dma_rd        DMA owns the WRAM read bus (READ state)
//   dma_addr      WRAM read address {page, idx}
//   oam_WE        one-clk OAM write strobe
//   oam_addr      oam_base + idx, wrapping at 256
//   oam_data      byte captured during READ
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int unsigned XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_WE,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  oam_base,
  input  logic [7:0]  wram_data,
  output logic        cpu_stall,
  output logic        oam_dma,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  output logic        oam_WE,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t      state;
  logic        par;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_q;
  logic        trigger;

  assign trigger = cpu_WE && (cpu_addr == DMA_REG_ADDR);

  // dma_addr is a register that already holds the next READ address while
  // HALT/ALIGN/WRITE is in progress, so a RAM with one clk of read latency
  // has its data ready even when READ lasts a single clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      par      <= 1'b0;
      page     <= '0;
      idx      <= '0;
      data_q   <= '0;
      dma_addr <= '0;
    end else if (cpu_ce) begin
      par <= ~par;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            page     <= cpu_data_in;
            idx      <= '0;
            dma_addr <= {cpu_data_in, 8'h00};
            state    <= HALT;
          end
        end
        // par=1 here means the next CPU cycle has par=0, i.e. a get cycle.
        HALT:  state <= par ? READ : ALIGN;
        ALIGN: state <= READ;
        READ: begin
          data_q   <= wram_data;
          dma_addr <= {page, idx + 8'd1};
          state    <= WRITE;
        end
        WRITE: begin
          idx   <= idx + 8'd1;
          state <= (idx == LAST_IDX) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_stall = (state != IDLE);
  assign oam_dma   = cpu_stall;
  assign dma_rd    = (state == READ);
  // Gated by reset so a write strobe cannot slip out on the clk that aborts.
  assign oam_WE    = (state == WRITE) && cpu_ce && !reset;
  assign oam_addr  = oam_base + idx;
  assign oam_data  = data_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed bench for oam_dma_ctrl. Models a WRAM with one
// clk of read latency and an OAM array written on oam_WE, then runs scenario
// tasks with hand-computed expectations.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce = 1'b0;
  logic [15:0] cpu_addr;
  logic        cpu_WE;
  logic [7:0]  cpu_data_in;
  logic [7:0]  oam_base;
  logic [7:0]  wram_data;
  logic        cpu_stall;
  logic        oam_dma;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic        oam_WE;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;

  oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014), .XFER_LEN(256)) dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr),
    .cpu_WE(cpu_WE), .cpu_data_in(cpu_data_in), .oam_base(oam_base),
    .wram_data(wram_data), .cpu_stall(cpu_stall), .oam_dma(oam_dma),
    .dma_rd(dma_rd), .dma_addr(dma_addr), .oam_WE(oam_WE),
    .oam_addr(oam_addr), .oam_data(oam_data)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0] ram [0:65535];
  logic [7:0] oam_mem [0:255];

  int unsigned ce_div = 1;
  int unsigned ce_cnt = 0;
  logic        par_m = 1'b0;

  // monitor-owned counters
  int unsigned stall_strobes_total = 0;
  int unsigned stall_clks_total = 0;
  int unsigned we_clks_total = 0;
  int unsigned rd_total = 0;
  int unsigned mon_err = 0;
  int unsigned fill_seen = 0;
  logic        prev_we_strobe = 1'b0;
  logic [15:0] exp_rd;

  // main-owned
  int unsigned fill_req = 0;
  logic [7:0]  fill_val = 8'h00;
  int unsigned rd_base = 0;
  logic [7:0]  xfer_page = 8'h00;
  int unsigned st_strobes, st_clks, st_we, st_err;

  always @(posedge clk) wram_data <= ram[dma_addr];

  // CPU parity as seen by the CPU side: cleared by reset, flips per strobe.
  always @(posedge clk) begin
    if (reset) par_m <= 1'b0;
    else if (cpu_ce) par_m <= ~par_m;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ce_cnt++;
      cpu_ce = ((ce_cnt % ce_div) == 0);
    end
  end

  always @(negedge clk) begin
    if (fill_req != fill_seen) begin
      for (int i = 0; i < 256; i++) oam_mem[i] = fill_val;
      fill_seen = fill_req;
    end
    if (cpu_stall === 1'b1) stall_clks_total++;
    if (cpu_stall === 1'b1 && cpu_ce) stall_strobes_total++;
    if (oam_dma !== cpu_stall) begin
      mon_err++;
      $display("[TB] monitor: oam_dma=%b cpu_stall=%b", oam_dma, cpu_stall);
    end
    if (oam_WE === 1'b1) begin
      we_clks_total++;
      oam_mem[oam_addr] = oam_data;
      if (cpu_ce !== 1'b1) begin
        mon_err++;
        $display("[TB] monitor: oam_WE high without cpu_ce");
      end
    end
    if (cpu_ce && !reset) begin
      if (oam_WE === 1'b1 && prev_we_strobe) begin
        mon_err++;
        $display("[TB] monitor: oam_WE in consecutive CPU cycles");
      end
      prev_we_strobe = (oam_WE === 1'b1);
    end
    if (dma_rd === 1'b1 && cpu_ce && !reset) begin
      exp_rd = {xfer_page, 8'(rd_total - rd_base)};
      if (dma_addr !== exp_rd) begin
        mon_err++;
        $display("[TB] monitor: dma_addr=%h expected %h", dma_addr, exp_rd);
      end
      rd_total++;
    end
  end

  task automatic fill_oam(input logic [7:0] v);
    fill_val = v;
    fill_req++;
    @(negedge clk);
    #1;
  endtask

  // Issue one CPU write on a strobe; optionally only on a strobe whose
  // parity equals want_par.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d,
                           input logic want_par, input bit use_par);
    bit found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cpu_ce && (!use_par || par_m == want_par)) begin
        found = 1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL write_slot: no strobe found, got 0 required 1");
    end
    cpu_addr    = a;
    cpu_WE      = 1'b1;
    cpu_data_in = d;
    @(posedge clk);
    #2;
    cpu_WE   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  // Trigger on a strobe with parity 0 (no ALIGN) or 1 (ALIGN visited).
  task automatic start_xfer(input logic [7:0] pg, input bit align);
    xfer_page  = pg;
    rd_base    = rd_total;
    st_strobes = stall_strobes_total;
    st_clks    = stall_clks_total;
    st_we      = we_clks_total;
    st_err     = mon_err;
    cpu_write(16'h4014, pg, align, 1);
    @(negedge clk);
    tests++;
    if (cpu_stall !== 1'b1) begin
      fails++;
      $display("FAIL stall_rise: cpu_stall=%b required 1", cpu_stall);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      #1;
      if (cpu_stall === 1'b0) begin
        done = 1;
        break;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL idle_timeout: cpu_stall still %b required 0", cpu_stall);
    end
  endtask

  task automatic check_counts(input int unsigned exp_strobes, input int unsigned exp_we);
    tests++;
    if (stall_strobes_total - st_strobes !== exp_strobes) begin
      fails++;
      $display("FAIL stall_strobes: got %0d required %0d", stall_strobes_total - st_strobes, exp_strobes);
    end
    tests++;
    if (we_clks_total - st_we !== exp_we) begin
      fails++;
      $display("FAIL we_count: got %0d required %0d", we_clks_total - st_we, exp_we);
    end
    tests++;
    if (mon_err !== st_err) begin
      fails++;
      $display("FAIL monitor: got %0d errors required 0", mon_err - st_err);
    end
  endtask

  task automatic check_oam_full(input logic [7:0] key, input logic [7:0] base);
    int unsigned bad = 0;
    logic [7:0] e;
    for (int i = 0; i < 256; i++) begin
      e = 8'(i) ^ key;
      if (oam_mem[8'(base + 8'(i))] !== e) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL oam_contents: %0d bad entries, required 0", bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_WE = 1'b0; cpu_addr = 16'h0000; cpu_data_in = 8'h00;
    oam_base = 8'h33;
    repeat (3) @(negedge clk);
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL rst_cpu_stall: got %b required 0", cpu_stall); end
    tests++; if (oam_dma !== 1'b0) begin fails++; $display("FAIL rst_oam_dma: got %b required 0", oam_dma); end
    tests++; if (dma_rd !== 1'b0) begin fails++; $display("FAIL rst_dma_rd: got %b required 0", dma_rd); end
    tests++; if (dma_addr !== 16'h0000) begin fails++; $display("FAIL rst_dma_addr: got %h required 0000", dma_addr); end
    tests++; if (oam_WE !== 1'b0) begin fails++; $display("FAIL rst_oam_WE: got %b required 0", oam_WE); end
    tests++; if (oam_addr !== 8'h33) begin fails++; $display("FAIL rst_oam_addr: got %h required 33", oam_addr); end
    tests++; if (oam_data !== 8'h00) begin fails++; $display("FAIL rst_oam_data: got %h required 00", oam_data); end
    // trigger while reset is held: reset wins
    cpu_write(16'h4014, 8'h02, 1'b0, 0);
    @(negedge clk);
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL rst_trigger: cpu_stall=%b required 0", cpu_stall); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_aligned();
    oam_base = 8'h00;
    fill_oam(8'hEE);
    start_xfer(8'h02, 0);
    wait_idle();
    check_counts(513, 256);
    check_oam_full(8'h5A, 8'h00);
  endtask

  task automatic test_align_path();
    fill_oam(8'h00);
    start_xfer(8'h02, 1);
    wait_idle();
    check_counts(514, 256);
    check_oam_full(8'h5A, 8'h00);
  endtask

  task automatic test_wrap();
    oam_base = 8'hF0;
    fill_oam(8'h00);
    start_xfer(8'h03, 0);
    wait_idle();
    check_counts(513, 256);
    tests++; if (oam_mem[8'hF0] !== 8'hC3) begin fails++; $display("FAIL wrap_f0: got %h required c3", oam_mem[8'hF0]); end
    tests++; if (oam_mem[8'h00] !== 8'hD3) begin fails++; $display("FAIL wrap_00: got %h required d3", oam_mem[8'h00]); end
    tests++; if (oam_mem[8'hEF] !== 8'h3C) begin fails++; $display("FAIL wrap_ef: got %h required 3c", oam_mem[8'hEF]); end
    oam_base = 8'h00;
  endtask

  task automatic test_retrigger();
    bit hit = 0;
    fill_oam(8'hEE);
    start_xfer(8'h02, 0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (rd_total - rd_base >= 40) begin hit = 1; break; end
    end
    tests++; if (!hit) begin fails++; $display("FAIL retrig_reach: idx 40 not reached, got 0 required 1"); end
    cpu_addr = 16'h4014; cpu_WE = 1'b1; cpu_data_in = 8'h07;
    @(posedge clk);
    #2;
    cpu_WE = 1'b0; cpu_addr = 16'h0000;
    repeat (4) @(negedge clk);
    tests++; if (dma_addr[15:8] !== 8'h02) begin fails++; $display("FAIL retrig_page: got %h required 02", dma_addr[15:8]); end
    wait_idle();
    check_counts(513, 256);
    check_oam_full(8'h5A, 8'h00);
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    int unsigned bad = 0;
    fill_oam(8'hEE);
    start_xfer(8'h02, 0);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (we_clks_total - st_we >= 100) begin hit = 1; break; end
    end
    tests++; if (!hit) begin fails++; $display("FAIL rmid_reach: idx 100 not reached, got 0 required 1"); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL rmid_stall: got %b required 0", cpu_stall); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    tests++; if (we_clks_total - st_we !== 100) begin fails++; $display("FAIL rmid_we: got %0d required 100", we_clks_total - st_we); end
    for (int i = 0; i < 256; i++) begin
      if (i < 100) begin
        if (oam_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
      end else if (oam_mem[i] !== 8'hEE) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rmid_oam: %0d bad entries, required 0", bad); end
    start_xfer(8'h03, 1);
    wait_idle();
    check_counts(514, 256);
    check_oam_full(8'hC3, 8'h00);
  endtask

  task automatic test_slow_ce();
    ce_div = 3;
    repeat (6) @(negedge clk);
    #1;
    st_clks = stall_clks_total;
    cpu_write(16'h4013, 8'h05, 1'b0, 0);
    cpu_write(16'h4015, 8'h06, 1'b0, 0);
    repeat (10) @(negedge clk);
    #1;
    tests++;
    if (stall_clks_total - st_clks !== 0 || cpu_stall !== 1'b0) begin
      fails++;
      $display("FAIL no_trigger: stall clks %0d required 0", stall_clks_total - st_clks);
    end
    fill_oam(8'h00);
    start_xfer(8'h02, 1);
    wait_idle();
    check_counts(514, 256);
    tests++;
    if (stall_clks_total - st_clks !== 1542) begin
      fails++;
      $display("FAIL slow_stall_clks: got %0d required 1542", stall_clks_total - st_clks);
    end
    check_oam_full(8'h5A, 8'h00);
  endtask

  initial begin
    logic [15:0] a;
    reset = 1'b1;
    cpu_WE = 1'b0;
    cpu_addr = 16'h0000;
    cpu_data_in = 8'h00;
    oam_base = 8'h00;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      a = 16'h0200 + 16'(i);
      ram[a] = 8'(i) ^ 8'h5A;
      a = 16'h0300 + 16'(i);
      ram[a] = 8'(i) ^ 8'hC3;
    end
    test_reset();
    test_aligned();
    test_align_path();
    test_wrap();
    test_retrigger();
    test_reset_mid();
    test_slow_ce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
